sbn_dmem_arbiter: RTL and testbench

Shares one single-port, synchronous-read SBN data memory between two requesters: requester 0 is an SBN core and requester 1 is a second core or a host loader/debug port.
- Arbitrates per cycle with round-robin priority.
- Supports a lock so a core can keep exclusive ownership across its read A / read B / write C sequence.
- Bounds lock ownership with a watchdog.
- Sits between the requesters and the dmem array.

---
 rtl/sbn_dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sbn_dmem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbn_dmem_arbiter.sv
// sbn_dmem_arbiter
// Shares one single-port, synchronous-read SBN data memory between two
// requesters. Requester 0 is an SBN core. Requester 1 is a second core or a
// host loader/debug port.
// - Per-cycle round-robin arbitration when the memory is not locked.
// - A requester can lock the memory across a read A / read B / write C
//   sequence, so the three accesses are not interleaved with the other side.
// - A watchdog bounds how long a lock may be held.
// - Read data comes straight from the memory one cycle after the grant.
//   It is qualified per requester by rvalid0/rvalid1.
module sbn_dmem_arbiter #(
    parameter int FWIDTH   = 8,
    parameter int DWIDTH   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [FWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,

    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [FWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,

    output logic [DWIDTH-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [FWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,

    output logic              lock_err
);

    // Lock ownership: FREE means no owner, HELDx means requester x owns it.
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        HELD0 = 2'd1,
        HELD1 = 2'd2
    } lock_state_t;

    // LOCK_MAX is limited to 255, so an 8-bit counter always suffices.
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

    lock_state_t state;
    lock_state_t state_nxt;
    logic [7:0]  lock_cnt;
    logic [7:0]  lock_cnt_nxt;
    logic        lock_err_nxt;
    logic        rr_last;      // requester granted most recently (loses next tie)
    logic        release0;     // owner 0 gives up the lock this cycle
    logic        release1;     // owner 1 gives up the lock this cycle

    // A lock ends on a granted access with lock low, or on lock low with no
    // request. The owner's request is always granted while it holds the lock,
    // so both cases come down to the same condition.
    assign release0 = (gnt0 && !lock0) || (!req0 && !lock0);
    assign release1 = (gnt1 && !lock1) || (!req1 && !lock1);

    // Grant decision: lock owner first, then round-robin on a conflict.
    // Grants are suppressed while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state)
                HELD0: gnt0 = req0;
                HELD1: gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        gnt0 = rr_last;
                        gnt1 = !rr_last;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    // Memory port mux. Addr/data/we are don't-care when nothing is granted.
    always_comb begin
        mem_en    = gnt0 || gnt1;
        mem_we    = gnt1 ? we1    : we0;
        mem_addr  = gnt1 ? addr1  : addr0;
        mem_wdata = gnt1 ? wdata1 : wdata0;
    end

    // Read data is not re-registered; rvalidN picks out whose data it is.
    assign rdata = mem_rdata;

    // Lock FSM next state, lock counter and watchdog.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        lock_err_nxt = 1'b0;
        case (state)
            FREE: begin
                lock_cnt_nxt = 8'd0;
                if (gnt0 && lock0) begin
                    state_nxt = HELD0;
                end else if (gnt1 && lock1) begin
                    state_nxt = HELD1;
                end
            end
            HELD0: begin
                lock_cnt_nxt = lock_cnt + 8'd1;
                if (release0) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = 8'd0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = 8'd0;
                    lock_err_nxt = 1'b1;
                end
            end
            HELD1: begin
                lock_cnt_nxt = lock_cnt + 8'd1;
                if (release1) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = 8'd0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = FREE;
                    lock_cnt_nxt = 8'd0;
                    lock_err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt    = FREE;
                lock_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Lock FSM state register. Reset drops any ownership immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FREE;
            lock_cnt <= 8'd0;
            lock_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            lock_err <= lock_err_nxt;
        end
    end

    // Round-robin pointer and read-valid flags.
    // Reset drops a pending rvalid. rr_last=1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            if (gnt0) begin
                rr_last <= 1'b0;
            end else if (gnt1) begin
                rr_last <= 1'b1;
            end
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
        end
    end

endmodule

// File: tb/tb_sbn_dmem_arbiter.sv
// Testbench for sbn_dmem_arbiter: directed scenarios plus a randomized run,
// checked against a transaction-level model of ownership, round-robin and
// memory contents kept in this file.
module tb_sbn_dmem_arbiter;

    localparam int FW = 8;
    localparam int DW = 32;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0, lock0, we0, req1, lock1, we1;
    logic [FW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, lock_err;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [FW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    sbn_dmem_arbiter #(.FWIDTH(FW), .DWIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port memory driven by the DUT.
    logic [DW-1:0] mem [0:(1<<FW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model: owner is -1 (none), 0 or 1.
    int            m_owner;
    bit            m_rr_last;
    int            m_cnt;
    bit            m_rv0, m_rv1, m_err;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] ref_mem [0:(1<<FW)-1];
    bit            e_g0, e_g1;

    task automatic model_reset();
        m_owner = -1; m_rr_last = 1'b1; m_cnt = 0;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_err = 1'b0;
    endtask

    // Expected grants for the current inputs and model state.
    task automatic model_eval();
        e_g0 = 1'b0; e_g1 = 1'b0;
        if (rst_n === 1'b1) begin
            if (m_owner == 0)      e_g0 = req0;
            else if (m_owner == 1) e_g1 = req1;
            else if (req0 && req1) begin
                if (m_rr_last) e_g0 = 1'b1;
                else           e_g1 = 1'b1;
            end else begin
                e_g0 = req0; e_g1 = req1;
            end
        end
    endtask

    // Apply one clock of the transaction-level rules.
    task automatic model_clock();
        bit nrv0, nrv1, nerr, lk;
        model_eval();
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            nrv0 = 1'b0; nrv1 = 1'b0; nerr = 1'b0;
            if (e_g0) begin
                m_rr_last = 1'b0;
                if (we0) ref_mem[addr0] = wdata0;
                else begin nrv0 = 1'b1; m_rdata = ref_mem[addr0]; end
            end
            if (e_g1) begin
                m_rr_last = 1'b1;
                if (we1) ref_mem[addr1] = wdata1;
                else begin nrv1 = 1'b1; m_rdata = ref_mem[addr1]; end
            end
            if (m_owner < 0) begin
                if (e_g0 && lock0)      begin m_owner = 0; m_cnt = 0; end
                else if (e_g1 && lock1) begin m_owner = 1; m_cnt = 0; end
            end else begin
                lk = (m_owner == 0) ? lock0 : lock1;
                if (!lk) m_owner = -1;
                else if (m_cnt == LM - 1) begin m_owner = -1; nerr = 1'b1; end
                else m_cnt++;
            end
            m_rv0 = nrv0; m_rv1 = nrv1; m_err = nerr;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; lock0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; lock1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0 = 1; req1 = 1;
        #3;
        tests_run++;
        if ({gnt0, gnt1, mem_en} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_gnt: {gnt0,gnt1,mem_en}=%b required 000", {gnt0, gnt1, mem_en});
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({rvalid0, rvalid1, lock_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_regs: {rvalid0,rvalid1,lock_err}=%b required 000", {rvalid0, rvalid1, lock_err});
        end
        idle();
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        idle();
        req0 = 1; addr0 = 8'h05;
        settle();
        tests_run++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'h05) begin
            tests_failed++;
            $display("FAIL single_gnt: gnt0=%b gnt1=%b mem_en=%b mem_addr=%h required 1 0 1 05",
                     gnt0, gnt1, mem_en, mem_addr);
        end
        advance();
        req0 = 0;
        settle();
        tests_run++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'd42) begin
            tests_failed++;
            $display("FAIL single_rdata: rvalid0=%b rvalid1=%b rdata=%0d required 1 0 42",
                     rvalid0, rvalid1, rdata);
        end
        advance();
    endtask

    task automatic test_round_robin();
        bit exp0, rv0x, rv1x;
        logic [DW-1:0] rdx;
        do_reset();
        req0 = 1; addr0 = 8'h20; req1 = 1; addr1 = 8'h21;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin req0 = 0; req1 = 0; end
            settle();
            if (i < 4) begin
                exp0 = (i % 2 == 0);
                tests_run++;
                if (gnt0 !== exp0 || gnt1 !== !exp0) begin
                    tests_failed++;
                    $display("FAIL rr_gnt%0d: gnt0=%b gnt1=%b required %b %b", i, gnt0, gnt1, exp0, !exp0);
                end
            end
            if (i > 0) begin
                rv0x = ((i - 1) % 2 == 0);
                rv1x = !rv0x;
                rdx  = rv0x ? ref_mem[8'h20] : ref_mem[8'h21];
                tests_run++;
                if (rvalid0 !== rv0x || rvalid1 !== rv1x || rdata !== rdx) begin
                    tests_failed++;
                    $display("FAIL rr_rvalid%0d: rvalid0=%b rvalid1=%b rdata=%h required %b %b %h",
                             i, rvalid0, rvalid1, rdata, rv0x, rv1x, rdx);
                end
            end
            advance();
        end
    endtask

    task automatic test_locked_seq();
        do_reset();
        req1 = 1; addr1 = 8'h40;
        for (int i = 0; i < 3; i++) begin
            req0 = 1;
            lock0 = (i < 2);
            we0 = (i == 2);
            addr0 = FW'(i + 1);
            wdata0 = 32'd7;
            settle();
            tests_run++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL lock_seq%0d: gnt0=%b gnt1=%b required 1 0", i, gnt0, gnt1);
            end
            if (i == 1) begin
                tests_run++;
                if (rvalid0 !== 1'b1 || rdata !== ref_mem[1]) begin
                    tests_failed++;
                    $display("FAIL lock_readA: rvalid0=%b rdata=%h required 1 %h", rvalid0, rdata, ref_mem[1]);
                end
            end
            advance();
        end
        req0 = 0; lock0 = 0; we0 = 0;
        settle();
        tests_run++;
        if (gnt1 !== 1'b1 || mem[3] !== 32'd7) begin
            tests_failed++;
            $display("FAIL lock_after: gnt1=%b dmem[3]=%0d required 1 7", gnt1, mem[3]);
        end
        advance();
        req1 = 0;
    endtask

    task automatic test_watchdog();
        do_reset();
        req0 = 1; lock0 = 1; addr0 = 8'h08;
        advance();
        req0 = 0; lock0 = 1; req1 = 1; addr1 = 8'h09;
        for (int i = 0; i < LM; i++) begin
            settle();
            tests_run++;
            if (gnt1 !== 1'b0 || lock_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL wd_held%0d: gnt1=%b lock_err=%b required 0 0", i, gnt1, lock_err);
            end
            advance();
        end
        settle();
        tests_run++;
        if (lock_err !== 1'b1 || gnt1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_fire: lock_err=%b gnt1=%b required 1 1", lock_err, gnt1);
        end
        advance();
        req1 = 0; lock0 = 0;
        settle();
        tests_run++;
        if (lock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_pulse: lock_err=%b required 0", lock_err);
        end
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        req0 = 1; lock0 = 1; addr0 = 8'h05; req1 = 1; addr1 = 8'h06;
        advance();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({gnt0, gnt1, mem_en, rvalid0} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_rst: {gnt0,gnt1,mem_en,rvalid0}=%b required 0000", {gnt0, gnt1, mem_en, rvalid0});
        end
        model_reset();
        rst_n = 1'b1;
        lock0 = 0;
        settle();
        tests_run++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_first: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end
        advance();
        idle();
    endtask

    task automatic test_write_read();
        idle();
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 32'hDEADBEEF;
        settle();
        tests_run++;
        if (gnt1 !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wr_gnt: gnt1=%b mem_we=%b mem_wdata=%h required 1 1 deadbeef", gnt1, mem_we, mem_wdata);
        end
        advance();
        idle();
        req0 = 1; addr0 = 8'h10;
        advance();
        req0 = 0;
        settle();
        tests_run++;
        if (rvalid0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wr_rd: rvalid0=%b rdata=%h required 1 deadbeef", rvalid0, rdata);
        end
        advance();
    endtask

    task automatic test_random();
        logic [FW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            lock0 = ($urandom_range(0, 2) == 0);
            lock1 = ($urandom_range(0, 3) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            addr0 = ($urandom_range(0, 9) == 0) ? '1 : FW'($urandom_range(0, 15));
            addr1 = ($urandom_range(0, 9) == 0) ? '1 : FW'($urandom_range(0, 15));
            wdata0 = $urandom;
            wdata1 = $urandom;
            settle();
            tests_run++;
            if (gnt0 !== e_g0 || gnt1 !== e_g1 || mem_en !== (e_g0 || e_g1)) begin
                tests_failed++;
                $display("FAIL rnd_gnt c=%0d: gnt0=%b gnt1=%b mem_en=%b required %b %b %b",
                         c, gnt0, gnt1, mem_en, e_g0, e_g1, e_g0 || e_g1);
            end
            if (e_g0 || e_g1) begin
                ea = e_g1 ? addr1 : addr0;
                ew = e_g1 ? we1 : we0;
                ed = e_g1 ? wdata1 : wdata0;
                tests_run++;
                if (mem_addr !== ea || mem_we !== ew || (ew && mem_wdata !== ed)) begin
                    tests_failed++;
                    $display("FAIL rnd_mem c=%0d: addr=%h we=%b wdata=%h required %h %b %h",
                             c, mem_addr, mem_we, mem_wdata, ea, ew, ed);
                end
            end
            tests_run++;
            if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1 || lock_err !== m_err) begin
                tests_failed++;
                $display("FAIL rnd_flags c=%0d: rvalid0=%b rvalid1=%b lock_err=%b required %b %b %b",
                         c, rvalid0, rvalid1, lock_err, m_rv0, m_rv1, m_err);
            end
            if (m_rv0 || m_rv1) begin
                tests_run++;
                if (rdata !== m_rdata) begin
                    tests_failed++;
                    $display("FAIL rnd_rdata c=%0d: rdata=%h required %h", c, rdata, m_rdata);
                end
            end
            advance();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < (1 << FW); i++) begin
            ref_mem[i] = $urandom;
            mem[i] = ref_mem[i];
        end
        ref_mem[5] = 32'd42;
        mem[5] = 32'd42;
        idle();
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_locked_seq();
        test_watchdog();
        test_async_reset();
        test_write_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
